// File: rtl/ref_window_buffer_pkg.sv
// Shared sizing helpers and default geometry for the reference-window buffer.
// Modules size themselves from their own parameters through these helpers.
package ref_win_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int PIX_W_DEF    = 8;
  localparam int WORD_PIX_DEF = 8;
  localparam int NBANK_DEF    = 4;
  localparam int DEPTH_DEF    = 23;

  localparam int ADDR_W = clog2(DEPTH_DEF);
  localparam int BANK_W = clog2(NBANK_DEF);
  localparam int WORD_W = WORD_PIX_DEF * PIX_W_DEF;

  // Ring position k banks after base.
  function automatic int rot_idx(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/ref_window_buffer_bank.sv
// One ring bank: 1RW DEPTH x WIDTH with synchronous read. The behavioural array
// stands in for the technology macro; only this wrapper would change for a port.
module ref_bank_sram
  import ref_win_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WORD_W,
  parameter int AW    = ADDR_W
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Read data only moves on a read access, so it holds while the ring is stalled.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      r_rdata       <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ref_window_buffer.sv
// Ring of NBANK banks holding reference block columns; once NBANK-1 columns are
// resident each accepted beat yields one search-window row for the SAD array.
module ref_window_buffer
  import ref_win_pkg::*;
#(
  parameter int PIX_W           = PIX_W_DEF,
  parameter int WORD_PIX        = WORD_PIX_DEF,
  parameter int NBANK           = NBANK_DEF,
  parameter int DEPTH           = DEPTH_DEF,
  parameter int OUT_PIX         = 23,
  parameter int BLOCKS_PER_LINE = 482,
  parameter int NEXT_ROW        = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_PIX*PIX_W-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_PIX*PIX_W-1:0]    out_data,
  output logic [clog2(DEPTH)-1:0]     out_row,
  output logic                        next_block,
  output logic                        line_done,
  output logic [clog2(NBANK)-1:0]     fill_cnt
);

  localparam int WW    = WORD_PIX * PIX_W;
  localparam int AW    = clog2(DEPTH);
  localparam int BW    = clog2(NBANK);
  localparam int KW    = clog2(BLOCKS_PER_LINE);
  localparam int CAT_W = (NBANK - 1) * WW;
  localparam int OUT_W = OUT_PIX * PIX_W;

  localparam logic [AW-1:0] ROW_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ROW_NB    = AW'(NEXT_ROW);
  localparam logic [BW-1:0] BANK_LAST = BW'(NBANK - 1);
  localparam logic [KW-1:0] BLK_LAST  = KW'(BLOCKS_PER_LINE - 1);

  logic [AW-1:0]  r_row;
  logic [BW-1:0]  r_wbank;
  logic [KW-1:0]  r_blk;
  logic [BW-1:0]  r_fill;
  logic           r_out_valid;
  logic [AW-1:0]  r_out_row;
  logic [BW-1:0]  r_out_wbank;
  logic           r_next_block;
  logic           r_line_done;

  logic           w_fire;
  logic           w_primed;
  logic           w_row_wrap;
  logic           w_line_end;
  logic [WW-1:0]  w_rdata [NBANK];
  logic [CAT_W-1:0] w_cat;
  logic           w_unused_cat;

  // Handshake: a beat moves when valid && ready on that side; the input side is
  // ready whenever the single output slot is empty or being drained this cycle.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_fire     = in_valid && in_ready;
  assign w_primed   = (r_fill == BANK_LAST);
  assign w_row_wrap = (r_row == ROW_LAST);
  assign w_line_end = w_row_wrap && (r_blk == BLK_LAST);

  // Every bank is accessed at r_row on a beat: the write bank writes, the rest read.
  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    ref_bank_sram #(
      .DEPTH (DEPTH),
      .WIDTH (WW),
      .AW    (AW)
    ) u_bank (
      .clk     (clk),
      .i_en    (w_fire),
      .i_we    (r_wbank == BW'(g)),
      .i_addr  (r_row),
      .i_wdata (in_data),
      .o_rdata (w_rdata[g])
    );
  end

  // Oldest bank (the one after the write bank of that beat) lands in the MSBs.
  always_comb begin
    logic [BW-1:0] idx;
    idx   = '0;
    w_cat = '0;
    for (int k = 1; k < NBANK; k++) begin
      idx = BW'(rot_idx(int'(r_out_wbank), k, NBANK));
      w_cat[(NBANK-1-k)*WW +: WW] = w_rdata[idx];
    end
  end

  assign w_unused_cat = ^w_cat;
  assign out_data     = r_out_valid ? w_cat[CAT_W-1 -: OUT_W] : '0;
  assign out_valid    = r_out_valid;
  assign out_row      = r_out_row;
  assign next_block   = r_next_block;
  assign line_done    = r_line_done;
  assign fill_cnt     = r_fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row        <= '0;
      r_wbank      <= '0;
      r_blk        <= '0;
      r_fill       <= '0;
      r_out_valid  <= 1'b0;
      r_out_row    <= '0;
      r_out_wbank  <= '0;
      r_next_block <= 1'b0;
      r_line_done  <= 1'b0;
    end else begin
      r_next_block <= r_out_valid && out_ready && (r_out_row == ROW_NB);
      r_line_done  <= w_fire && w_line_end;
      if (w_fire) begin
        r_out_valid <= w_primed;
        if (w_primed) begin
          r_out_row   <= r_row;
          r_out_wbank <= r_wbank;
        end
        if (w_row_wrap) begin
          r_row <= '0;
          if (w_line_end) begin
            r_blk   <= '0;
            r_wbank <= '0;
            r_fill  <= '0;
          end else begin
            r_blk   <= r_blk + 1'b1;
            r_wbank <= (r_wbank == BANK_LAST) ? '0 : r_wbank + 1'b1;
            if (!w_primed) r_fill <= r_fill + 1'b1;
          end
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ref_window_buffer.sv
// Bench for ref_window_buffer with a 6-block line: reference model of the bank ring,
// expected-row queue checked on every output, phase table plus corner sequences.
module tb_ref_window_buffer;

  localparam int PIX_W    = 8;
  localparam int WORD_PIX = 8;
  localparam int NBANK    = 4;
  localparam int DEPTH    = 23;
  localparam int OUT_PIX  = 23;
  localparam int BPL      = 6;
  localparam int NEXT_ROW = 9;
  localparam int WW       = WORD_PIX * PIX_W;
  localparam int OW       = OUT_PIX * PIX_W;
  localparam int CAT_W    = (NBANK - 1) * WW;
  localparam int RW       = 5;
  localparam int EW       = RW + OW;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic          next_block;
  logic          line_done;
  logic [1:0]    fill_cnt;

  ref_window_buffer #(
    .PIX_W(PIX_W), .WORD_PIX(WORD_PIX), .NBANK(NBANK), .DEPTH(DEPTH),
    .OUT_PIX(OUT_PIX), .BLOCKS_PER_LINE(BPL), .NEXT_ROW(NEXT_ROW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .next_block(next_block), .line_done(line_done), .fill_cnt(fill_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  logic [EW-1:0] exp_q[$];
  logic [WW-1:0] m_mem [NBANK][DEPTH];
  int   m_row, m_wbank, m_blk, m_fill;
  logic m_out_valid;
  int   n_chk, n_err, n_nb, n_ld, n_out;

  typedef struct {
    int beats; int gap; int stall;
    int exp_out; int exp_nb; int exp_ld; int exp_fill;
  } vec_t;
  vec_t vec[7];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: got timeout/empty expected event", name);
  endtask

  task automatic model_reset();
    m_row = 0; m_wbank = 0; m_blk = 0; m_fill = 0;
    m_out_valid = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic v, input logic r, output logic acc, output logic [WW-1:0] d);
    logic exp_rdy, xfer, exp_nb, exp_ld;
    logic [EW-1:0] front;
    logic [CAT_W-1:0] cat;
    d = {$urandom(), $urandom()};
    in_valid = v; in_data = d; out_ready = r;
    #1;
    exp_rdy = !m_out_valid || r;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_out_valid);
    if (out_valid && r) n_out++;
    xfer = m_out_valid && r;
    exp_nb = 1'b0;
    if (m_out_valid) begin
      if (exp_q.size() == 0) begin
        fail("queue_empty");
      end else begin
        front = exp_q[0];
        check("out_row", out_row, front[EW-1 -: RW]);
        check("out_data", out_data, front[OW-1:0]);
        if (xfer) begin
          void'(exp_q.pop_front());
          exp_nb = (front[EW-1 -: RW] == RW'(NEXT_ROW));
        end
      end
    end
    acc = v && exp_rdy;
    exp_ld = acc && (m_row == DEPTH - 1) && (m_blk == BPL - 1);
    if (acc) begin
      if (m_fill == NBANK - 1) begin
        cat = '0;
        for (int k = 1; k < NBANK; k++)
          cat = (cat << WW) | CAT_W'(m_mem[(m_wbank + k) % NBANK][m_row]);
        exp_q.push_back({RW'(m_row), OW'(cat >> (CAT_W - OW))});
        m_out_valid = 1'b1;
      end else begin
        m_out_valid = 1'b0;
      end
      m_mem[m_wbank][m_row] = d;
      if (m_row == DEPTH - 1) begin
        m_row = 0;
        if (m_blk == BPL - 1) begin
          m_blk = 0; m_wbank = 0; m_fill = 0;
        end else begin
          m_blk++;
          m_wbank = (m_wbank + 1) % NBANK;
          if (m_fill < NBANK - 1) m_fill++;
        end
      end else begin
        m_row++;
      end
    end else if (r) begin
      m_out_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("next_block", next_block, exp_nb);
    check("line_done", line_done, exp_ld);
    check("fill_cnt", fill_cnt, m_fill);
    n_nb += int'(next_block);
    n_ld += int'(line_done);
  endtask

  task automatic drain();
    logic acc;
    logic [WW-1:0] d;
    int n;
    n = 0;
    while (m_out_valid && n < 5) begin
      cycle(1'b0, 1'b1, acc, d);
      n++;
    end
    if (m_out_valid) fail("drain_timeout");
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_row", out_row, 0);
    check("rst_next_block", next_block, 0);
    check("rst_line_done", line_done, 0);
    check("rst_fill_cnt", fill_cnt, 0);
    rst = 1'b0;
  endtask

  task automatic run_phase(input int i);
    int got, cyc, nb0, ld0, out0;
    logic acc, v, r;
    logic [WW-1:0] d;
    nb0 = n_nb; ld0 = n_ld; out0 = n_out; got = 0; cyc = 0;
    while (got < vec[i].beats && cyc < vec[i].beats * 20 + 50) begin
      v = ($urandom_range(99) >= vec[i].gap);
      r = ($urandom_range(99) >= vec[i].stall);
      cycle(v, r, acc, d);
      got += int'(acc);
      cyc++;
    end
    if (got < vec[i].beats) fail("phase_timeout");
    drain();
    check("phase_outputs", n_out - out0, vec[i].exp_out);
    check("phase_next_block", n_nb - nb0, vec[i].exp_nb);
    check("phase_line_done", n_ld - ld0, vec[i].exp_ld);
    check("phase_fill_cnt", fill_cnt, vec[i].exp_fill);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic acc;
    logic [WW-1:0] d, w0, w1, w2;
    n_chk = 0; n_err = 0; n_nb = 0; n_ld = 0; n_out = 0;
    w0 = '0; w1 = '0; w2 = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();

    //          beats gap stall out nb ld fill
    vec[0] = '{22,  0,  0,  22, 1, 0, 3};   // rest of block 3
    vec[1] = '{23, 30, 30,  23, 1, 0, 3};   // block 4, gaps and stalls
    vec[2] = '{23,  0, 50,  23, 1, 1, 0};   // block 5, ends the line
    vec[3] = '{69, 20,  0,   0, 0, 0, 3};   // refill of the next line
    vec[4] = '{34, 10, 20,  34, 2, 0, 3};   // block 3 and block 4 rows 0..10
    vec[5] = '{69, 15, 15,   0, 0, 0, 3};   // refill after mid-block reset
    vec[6] = '{23, 25, 25,  23, 1, 0, 3};

    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Cold start: 69 silent beats, beat 70 yields {bank0[0], bank1[0], top 7 px of bank2[0]}.
    for (int b = 0; b < 70; b++) begin
      cycle(1'b1, 1'b1, acc, d);
      if (b == 0)  w0 = d;
      if (b == 23) w1 = d;
      if (b == 46) w2 = d;
    end
    check("first_out_valid", out_valid, 1);
    check("first_out_row", out_row, 0);
    check("first_out_data", out_data, {w0, w1, w2[WW-1:8]});

    // Five-cycle consumer stall with input pending.
    for (int s = 0; s < 5; s++) begin
      cycle(1'b1, 1'b0, acc, d);
      check("stall_no_accept", acc, 0);
    end
    drain();

    for (int i = 0; i < 5; i++) run_phase(i);

    // Pending output at block 4 row 11, then reset discards it.
    check("pre_reset_row", m_row, 11);
    cycle(1'b1, 1'b0, acc, d);
    check("pre_reset_pending", out_valid, 1);
    do_reset();

    for (int i = 5; i < 7; i++) run_phase(i);

    check("queue_empty_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ref_window_buffer.md
# ref_window_buffer

Parametrised reference-window buffer for the motion-estimation datapath. It accepts reference pixels one word per beat into a ring of NBANK single-port banks and, once NBANK-1 block columns are resident, emits one OUT_PIX-wide search-window row per accepted beat. It supersedes the fixed 4-bank, 23-row, free-running window store. New features are valid/ready flow control on both sides, a parametrised geometry, and a line-done status. It sits between the external reference fetch and the SAD array; `next_block` still paces the current-block buffer.

## Interface
- PIX_W, 8: bits per pixel
- WORD_PIX, 8: pixels per input word
- NBANK, 4: banks in the ring (≥2)
- DEPTH, 23: rows per block column; words per bank
- OUT_PIX, 23: pixels per output row; must be ≤ (NBANK-1)*WORD_PIX
- BLOCKS_PER_LINE, 482: block columns per reference line
- NEXT_ROW, 9: output row that raises `next_block`; must be < DEPTH
- clk, in, 1: clock
- rst, in, 1: reset, synchronous, active-high
- in_valid, in, 1: `in_data` valid
- in_ready, out, 1: beat accepted when `in_valid && in_ready`
- in_data, in, WORD_PIX*PIX_W: one row of one block column; leftmost pixel in the MSBs
- out_valid, out, 1: `out_data` valid
- out_ready, in, 1: consumer accepts the output
- out_data, out, OUT_PIX*PIX_W: window row; oldest bank in the MSBs
- out_row, out, clog2(DEPTH): row index of `out_data`
- next_block, out, 1: one-cycle pulse
- line_done, out, 1: one-cycle pulse
- fill_cnt, out, clog2(NBANK): completed blocks in the current line, saturating at NBANK-1

## Operation
- State registers:
  - `row` (0..DEPTH-1): shared by all banks.
  - `wbank` (0..NBANK-1).
  - `blk` (0..BLOCKS_PER_LINE-1).
  - `fill_cnt`.
  - primed = (fill_cnt == NBANK-1).
- Accepted beat:
  - Write `in_data` to bank `wbank` at `row`.
  - Issue a read of `row` in every other bank in the same cycle. The write bank is never read, so there is no read/write collision.
- Row advance:
  - `row` increments on each accepted beat and holds on idle cycles.
  - At `row == DEPTH-1`: `row` goes to 0 and `wbank` goes to (wbank+1) mod NBANK.
  - At that same wrap, `fill_cnt` increments if not primed, and `blk` increments.
- Line end (wrap with `blk == BLOCKS_PER_LINE-1`):
  - `blk`, `wbank` and `fill_cnt` go to 0; `line_done` pulses.
  - The next line must refill NBANK-1 blocks before any output.
- Output assembly:
  - Only beats accepted while primed produce output.
  - `out_data` = concatenation of banks (wbank+1) … (wbank+NBANK-1) mod NBANK, using `wbank` sampled at the beat, oldest first.
  - The concatenation is truncated to its top OUT_PIX*PIX_W bits.
- Flow control:
  - `in_ready = !out_valid || out_ready`.
  - While stalled, `out_data`, `out_row` and `out_valid` hold.
  - Unprimed beats are always accepted when `in_ready` is high.
- `next_block`: pulses for one cycle when an output with `out_row == NEXT_ROW` is transferred (`out_valid && out_ready`).
- Reset:
  - Outputs: `in_ready` = 1; `out_valid`, `next_block`, `line_done` = 0; `out_data` = 0; `out_row` = 0; `fill_cnt` = 0.
  - State: `row`, `wbank`, `blk` = 0.
  - Bank contents are not cleared; they are harmless because the block is unprimed after reset.
  - A reset mid-block discards the partial block and any pending output.

## Timing
- Banks use synchronous read. Output for a beat accepted in cycle t is valid in cycle t+1.
- `out_valid` clears in the cycle after a transfer unless a new primed beat was also accepted; back-to-back throughput is 1 row per cycle.
- Cold start: DEPTH*(NBANK-1) accepted beats (69 with default parameters) before the first accepted beat that produces output.
- `line_done` asserts in the cycle after the final beat of the line is accepted.
- If that final beat produced output, `out_valid` is also high in the same cycle as `line_done`.
- Stall during a wrap: the wrap is taken on acceptance. The stalled output keeps the `wbank` ordering from its own beat.

## Structure
- Shared package `ref_win_pkg` holds:
  - a clog2 helper;
  - localparams ADDR_W, BANK_W, WORD_W = WORD_PIX*PIX_W;
  - a bank-index rotation function, (base+k) mod NBANK.
- Sub-module `ref_bank_sram`: 1RW, DEPTH × WORD_W, synchronous read, write-enable.
  - Instantiated NBANK times in a generate loop.
  - The technology SRAM macro is wrapped inside it; no other file references the macro.

## Test plan
- Default params, reset, then 69 continuous beats with `out_ready=1`:
  - `out_valid` stays 0.
  - Beat 70 (block 3, row 0): `out_valid=1` next cycle, `out_data` = {bank0[0], bank1[0], top 7 px of bank2[0]}, `out_row=0`.
- Steady state with `out_ready` held low for 5 cycles:
  - `in_ready=0` throughout; `out_data` is stable.
  - After release, the row sequence continues with no gap or duplicate.
- Primed stream: `next_block` is high exactly one cycle per block, on the transfer with `out_row=9`.
- BLOCKS_PER_LINE=6:
  - `line_done` pulses after beat 138.
  - The next 69 beats give no output; `fill_cnt` counts 0→3; ordering restarts with bank0 as the oldest bank.
- `rst` asserted at block 4, row 11:
  - Next cycle: `out_valid=0`, `fill_cnt=0`.
  - 69 beats are again needed before the first output.
- Random `in_valid` gaps: `row` holds across idle cycles, and the output matches a reference model beat for beat.
